// File: rtl/pll_pkg.sv
// Shared constants and state type for the PLL lock detector.
package pll_pkg;

    localparam int DIV_RATIO       = 64;  // Fin / F_PFD at lock
    localparam int WIN_LEN_DEF     = 16;
    localparam int EXP_CNT_DEF     = 16;
    localparam int TOL_DEF         = 1;
    localparam int LOCK_WINS_DEF   = 4;
    localparam int UNLOCK_WINS_DEF = 2;
    localparam int CW_DEF          = 8;

    typedef enum logic {IDLE, MEASURE} lock_state_t;

endpackage

// File: rtl/pll_lock_detect_ref_sync.sv
// Brings Fref into the Fin domain: 2-FF synchronizer plus an edge register,
// producing a one-cycle ref_rise pulse.
module ref_sync (
    input  logic Fin,
    input  logic Resetn,
    input  logic Fref,
    output logic ref_rise
);

    // [0],[1]: metastability stages; [2]: previous synchronized level
    logic [2:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[1:0], Fref};

    always_ff @(posedge Fin or negedge Resetn) begin
        if (!Resetn) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign ref_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pll_lock_detect.sv
// Window-based PLL lock detector: counts F_PFD edges per WIN_LEN Fref edges.
// Optional FreqErr output enabled by defining PLL_LOCK_ERR_EN.
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int WIN_LEN     = WIN_LEN_DEF,
    parameter int EXP_CNT     = EXP_CNT_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int LOCK_WINS   = LOCK_WINS_DEF,
    parameter int UNLOCK_WINS = UNLOCK_WINS_DEF,
    parameter int CW          = CW_DEF
) (
    input  logic              Fin,
    input  logic              Resetn,
    input  logic              Fref,
    input  logic              F_PFD,
    input  logic              LockLostClr,
    output logic              Locked,
    output logic              LockLost,
    output logic              WinDone
`ifdef PLL_LOCK_ERR_EN
    ,
    output logic signed [CW:0] FreqErr
`endif
);

    localparam int RMAX = (LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0]        CNT_MAX = '1;
    localparam logic signed [CW:0]   TOL_S   = (CW+1)'(TOL);

    lock_state_t       state_q, state_d;
    logic [CW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [CW-1:0]     pfd_cnt_q, pfd_cnt_d;
    logic [RW-1:0]     good_run_q, good_run_d;
    logic [RW-1:0]     bad_run_q, bad_run_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;
    logic              win_done_q, win_done_d;
    logic              f_pfd_q;
`ifdef PLL_LOCK_ERR_EN
    logic signed [CW:0] ferr_q, ferr_d;
`endif

    logic              ref_rise, pfd_rise, good;
    logic [CW-1:0]     pfd_inc, cnt_eval;
    logic signed [CW:0] err;

    ref_sync u_ref_sync (
        .Fin      (Fin),
        .Resetn   (Resetn),
        .Fref     (Fref),
        .ref_rise (ref_rise)
    );

    // A pfd_rise coincident with the window-ending ref_rise belongs to that window
    always_comb begin
        pfd_rise = F_PFD & ~f_pfd_q;
        pfd_inc  = (pfd_cnt_q == CNT_MAX) ? CNT_MAX : pfd_cnt_q + CW'(1);
        cnt_eval = pfd_rise ? pfd_inc : pfd_cnt_q;
        err      = $signed({1'b0, cnt_eval}) - $signed((CW+1)'(EXP_CNT));
        good     = (cnt_eval != CNT_MAX) && (err <= TOL_S) && (err >= -TOL_S);
    end

    always_comb begin
        state_d    = state_q;
        ref_cnt_d  = ref_cnt_q;
        pfd_cnt_d  = pfd_cnt_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        locked_d   = locked_q;
        lost_d     = LockLostClr ? 1'b0 : lost_q;
        win_done_d = 1'b0;
`ifdef PLL_LOCK_ERR_EN
        ferr_d     = ferr_q;
`endif
        case (state_q)
            IDLE: begin
                if (ref_rise) begin
                    state_d   = MEASURE;
                    ref_cnt_d = '0;
                    pfd_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (pfd_rise) pfd_cnt_d = pfd_inc;
                if (ref_rise) begin
                    if (ref_cnt_q == CW'(WIN_LEN - 1)) begin
                        ref_cnt_d  = '0;
                        pfd_cnt_d  = '0;
                        win_done_d = 1'b1;
`ifdef PLL_LOCK_ERR_EN
                        ferr_d     = err;
`endif
                        if (good) begin
                            bad_run_d  = '0;
                            if (good_run_q != RW'(LOCK_WINS)) good_run_d = good_run_q + RW'(1);
                        end else begin
                            good_run_d = '0;
                            if (bad_run_q != RW'(UNLOCK_WINS)) bad_run_d = bad_run_q + RW'(1);
                        end
                        // Loss event overrides a same-cycle LockLostClr
                        if (!locked_q && good_run_d == RW'(LOCK_WINS)) begin
                            locked_d = 1'b1;
                        end else if (locked_q && bad_run_d == RW'(UNLOCK_WINS)) begin
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                        end
                    end else begin
                        ref_cnt_d = ref_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Fin or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            ref_cnt_q  <= '0;
            pfd_cnt_q  <= '0;
            good_run_q <= '0;
            bad_run_q  <= '0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
            win_done_q <= 1'b0;
            f_pfd_q    <= 1'b0;
`ifdef PLL_LOCK_ERR_EN
            ferr_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            pfd_cnt_q  <= pfd_cnt_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
            win_done_q <= win_done_d;
            f_pfd_q    <= F_PFD;
`ifdef PLL_LOCK_ERR_EN
            ferr_q     <= ferr_d;
`endif
        end
    end

    assign Locked   = locked_q;
    assign LockLost = lost_q;
    assign WinDone  = win_done_q;
`ifdef PLL_LOCK_ERR_EN
    assign FreqErr  = ferr_q;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: directed window table plus random windows,
// checked against a window-history lock model.
module tb_pll_lock_detect;

    localparam int EXP = 16;
    localparam int TOLB = 1;
    localparam int SAT = 255;

    logic Fin = 1'b0, Resetn = 1'b0, Fref = 1'b0, F_PFD = 1'b0, LockLostClr = 1'b0;
    logic Locked, LockLost, WinDone;
`ifdef PLL_LOCK_ERR_EN
    logic signed [8:0] FreqErr;
`endif

    pll_lock_detect dut (
        .Fin         (Fin),
        .Resetn      (Resetn),
        .Fref        (Fref),
        .F_PFD       (F_PFD),
        .LockLostClr (LockLostClr),
        .Locked      (Locked),
        .LockLost    (LockLost),
        .WinDone     (WinDone)
`ifdef PLL_LOCK_ERR_EN
        ,
        .FreqErr     (FreqErr)
`endif
    );

    always #5 Fin = ~Fin;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {int n; bit al; int clr; bit has; bit el; bit elost;} row_t;
    typedef struct {int cnt; bit has; bit el; bit elost; int idx;} exp_t;

    exp_t q[$];
    bit   hist[$];
    bit   m_locked = 1'b0, m_lost = 1'b0;
    int   pushed = 0, popped = 0;
    bit   align_pend = 1'b0;
    int   clr_pos = 0;

    // Reference model: lock decided from the history of window verdicts
    always @(negedge Fin) begin
        if (Resetn && WinDone === 1'b1) begin
            if (q.size() == 0) begin
                chk("windone_unexpected", 1, 0);
            end else begin
                exp_t e;
                int cnt, nh;
                bit good;
                e = q.pop_front();
                popped++;
                cnt  = (e.cnt > SAT) ? SAT : e.cnt;
                good = (cnt < SAT) && (cnt - EXP <= TOLB) && (EXP - cnt <= TOLB);
                hist.push_back(good);
                nh = hist.size();
                if (!m_locked) begin
                    m_locked = (nh >= 4) && hist[nh-1] && hist[nh-2] && hist[nh-3] && hist[nh-4];
                end else if (nh >= 2 && !hist[nh-1] && !hist[nh-2]) begin
                    m_locked = 1'b0;
                    m_lost   = 1'b1;
                end
                chk($sformatf("locked win %0d", e.idx), Locked, m_locked);
                chk($sformatf("locklost win %0d", e.idx), LockLost, m_lost);
                if (e.has) begin
                    chk($sformatf("tbl_locked row %0d", e.idx), Locked, e.el);
                    chk($sformatf("tbl_locklost row %0d", e.idx), LockLost, e.elost);
                end
`ifdef PLL_LOCK_ERR_EN
                chk($sformatf("freq_err win %0d", e.idx), FreqErr, cnt - EXP);
`endif
            end
        end
    end

    // One Fref period carrying c F_PFD pulses; also applies pending align/clear
    task automatic do_period(input int c);
        int per, cp;
        bit a;
        per = (2*c + 6 > 16) ? 2*c + 6 : 16;
        cp = clr_pos; a = align_pend;
        clr_pos = 0; align_pend = 1'b0;
        for (int p = 0; p < per; p++) begin
            @(posedge Fin); #2;
            Fref        = (p < per/2);
            F_PFD       = (a && p == 2) || (p >= 4 && (p % 2) == 0 && (p - 4)/2 < c);
            LockLostClr = (cp != 0 && p == cp);
            if (cp != 0 && p == cp + 1) m_lost = 1'b0;
            if (cp != 0 && p == cp + 2) begin
                #1 chk("locklost_after_clr", LockLost, m_lost);
            end
        end
    endtask

    task automatic run_window(input int n, input bit al, input int clr,
                              input bit has, input bit el, input bit elost, input int idx);
        exp_t e;
        for (int k = 0; k < 16; k++) do_period(n/16 + ((k < n % 16) ? 1 : 0));
        align_pend = al;
        clr_pos    = clr;
        e.cnt = n + (al ? 1 : 0); e.has = has; e.el = el; e.elost = elost; e.idx = idx;
        q.push_back(e);
        pushed++;
    endtask

    row_t tbl[34];

    initial begin
        // n, align, clr_pos, has_exp, exp_locked, exp_locklost
        tbl = '{
            '{16,0,0,1,0,0}, '{16,0,0,1,0,0}, '{16,0,0,1,0,0}, '{16,0,0,1,1,0},
            '{14,0,0,1,1,0}, '{14,0,8,1,0,1},
            '{17,0,0,1,0,0}, '{17,0,0,1,0,0}, '{17,0,0,1,0,0}, '{17,0,0,1,1,0},
            '{14,0,0,1,1,0}, '{14,0,2,1,0,1},
            '{18,0,0,1,0,1}, '{18,0,0,1,0,1},
            '{16,0,0,1,0,1}, '{18,0,0,1,0,1}, '{16,0,0,1,0,1}, '{18,0,0,1,0,1},
            '{16,0,0,1,0,1}, '{18,0,8,1,0,1},
            '{16,0,0,1,0,0}, '{16,0,0,1,0,0}, '{16,0,0,1,0,0}, '{16,0,0,1,1,0},
            '{17,1,0,1,1,0}, '{14,0,8,1,0,1},
            '{16,0,0,1,0,0}, '{16,0,0,1,0,0}, '{16,0,0,1,0,0}, '{16,0,0,1,1,0},
            '{13,1,0,1,1,0}, '{17,0,0,1,1,0},
            '{300,0,0,1,1,0}, '{300,0,0,1,0,1}
        };

        repeat (3) @(posedge Fin);
        #1;
        chk("reset_locked", Locked, 0);
        chk("reset_locklost", LockLost, 0);
        chk("reset_windone", WinDone, 0);
`ifdef PLL_LOCK_ERR_EN
        chk("reset_freqerr", FreqErr, 0);
`endif
        @(posedge Fin); #2 Resetn = 1'b1;

        for (int i = 0; i < 34; i++)
            run_window(tbl[i].n, tbl[i].al, tbl[i].clr, tbl[i].has, tbl[i].el, tbl[i].elost, i);

        for (int i = 0; i < 20; i++) begin
            int n, clr, sel;
            bit al;
            n   = $urandom_range(13, 19);
            al  = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 4);
            clr = (sel == 3) ? 2 : (sel == 4) ? 8 : 0;
            run_window(n, al, clr, 1'b0, 1'b0, 1'b0, 100 + i);
        end

        for (int i = 0; i < 4; i++) run_window(16, 1'b0, 0, 1'b0, 1'b0, 1'b0, 200 + i);

        // Partial window with F_PFD activity, then reset while locked
        for (int i = 0; i < 3; i++) do_period(2);
        #1 chk("locked_before_reset", Locked, 1);
        repeat (4) begin @(posedge Fin); #2; end
        Resetn = 1'b0;
        #1;
        chk("midreset_locked", Locked, 0);
        chk("midreset_locklost", LockLost, 0);
        chk("midreset_windone", WinDone, 0);
        chk("midreset_queue_empty", q.size(), 0);
        q.delete(); hist.delete();
        m_locked = 1'b0; m_lost = 1'b0;
        repeat (3) @(posedge Fin);
        #2 Resetn = 1'b1;

        for (int i = 0; i < 4; i++)
            run_window(16, 1'b0, 0, 1'b1, (i == 3), 1'b0, 300 + i);
        do_period(0);
        do_period(0);

        chk("windows_evaluated", popped, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
